// File: rtl/reduce_mean_divider_if.sv
// Handshake bundle for reduce_mean_divider: sum input channel and mean output channel.
// A transfer happens on a rising edge where valid and ready are both high; the sender
// holds valid and its payload stable until that edge, and ready never depends on valid.
interface reduce_mean_divider_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_rem;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_rem, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_rem, out_tag
  );
endinterface

// File: rtl/reduce_mean_divider.sv
// Turns a reduced signed sum into a mean: sequential restoring divide by the constant
// DIVISOR, one quotient bit per cycle, quotient truncated toward zero.
module reduce_mean_divider #(
  parameter int DATA_W  = 32,
  parameter int DIVISOR = 256,
  parameter int TAG_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  reduce_mean_divider_if.slave bus,
  output logic [1:0]           o_dbg_state
);

  localparam longint DIV_MAX = (longint'(1) << (DATA_W - 1)) - 1;
  localparam int     CNT_W   = $clog2(DATA_W + 1);
  localparam logic [DATA_W:0] DIV_EXT = (DATA_W + 1)'(DIVISOR);

  if (DIVISOR < 1 || longint'(DIVISOR) > DIV_MAX) begin : g_bad_divisor
    $error("reduce_mean_divider: DIVISOR out of range 1 .. 2^(DATA_W-1)-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_sign;
  logic [DATA_W-1:0]  r_mag;
  logic [DATA_W-1:0]  r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_out_data;
  logic [DATA_W-1:0]  r_out_rem;
  logic [TAG_W-1:0]   r_out_tag;

  logic [DATA_W-1:0]  w_abs;
  logic [DATA_W:0]    w_shift;
  logic [DATA_W:0]    w_diff;
  logic               w_ge;
  logic [DATA_W-1:0]  w_rem_next;
  logic [DATA_W-1:0]  w_quo_next;
  logic               w_last;

  // -2^(DATA_W-1) negates to itself, which read as unsigned is the exact magnitude.
  assign w_abs = bus.in_data[DATA_W-1] ? (~bus.in_data + 1'b1) : bus.in_data;

  // Partial remainder stays below DIVISOR, so the shifted value and the difference fit
  // DATA_W+1 bits and the difference's top bit is a valid borrow.
  assign w_shift    = {r_rem, r_mag[DATA_W-1]};
  assign w_diff     = w_shift - DIV_EXT;
  assign w_ge       = ~w_diff[DATA_W];
  assign w_rem_next = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  // Quotient bits shift into the magnitude register as dividend bits shift out.
  assign w_quo_next = {r_mag[DATA_W-2:0], w_ge};
  assign w_last     = (r_cnt == CNT_W'(1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_next = S_DIV;
      S_DIV:   if (w_last) w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sign     <= 1'b0;
      r_mag      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_out_data <= '0;
      r_out_rem  <= '0;
      r_out_tag  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sign <= bus.in_data[DATA_W-1];
            r_mag  <= w_abs;
            r_tag  <= bus.in_tag;
            r_rem  <= '0;
            r_cnt  <= CNT_W'(DATA_W);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_mag <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_out_data <= r_sign ? (~w_quo_next + 1'b1) : w_quo_next;
            r_out_rem  <= r_sign ? (~w_rem_next + 1'b1) : w_rem_next;
            r_out_tag  <= r_tag;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_rem   = r_out_rem;
  assign bus.out_tag   = r_out_tag;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_reduce_mean_divider.sv
// Directed bench for reduce_mean_divider with DIVISOR = 256, 1 and 3 instances.
module tb_reduce_mean_divider;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state1;
  logic [1:0] dbg_state3;

  reduce_mean_divider_if #(.DATA_W(32), .TAG_W(8)) u_if ();
  reduce_mean_divider_if #(.DATA_W(32), .TAG_W(8)) u_if1 ();
  reduce_mean_divider_if #(.DATA_W(32), .TAG_W(8)) u_if3 ();

  reduce_mean_divider #(.DATA_W(32), .DIVISOR(256), .TAG_W(8)) u_dut (
    .clk(clk), .rst(rst), .bus(u_if.slave), .o_dbg_state(dbg_state)
  );
  reduce_mean_divider #(.DATA_W(32), .DIVISOR(1), .TAG_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if1.slave), .o_dbg_state(dbg_state1)
  );
  reduce_mean_divider #(.DATA_W(32), .DIVISOR(3), .TAG_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .bus(u_if3.slave), .o_dbg_state(dbg_state3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  logic [71:0] exp_q[$];

  always @(posedge clk) begin
    if (u_if.out_valid && u_if.out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send(input logic [31:0] d, input logic [7:0] t);
    int n = 0;
    while (!u_if.in_ready && n < 300) begin
      step();
      n++;
    end
    check("send_ready", u_if.in_ready, 1);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    u_if.in_tag   = t;
    step();
    u_if.in_valid = 1'b0;
  endtask

  task automatic recv(input string name, input logic [31:0] eq, input logic [31:0] er,
                      input logic [7:0] et);
    int n = 0;
    u_if.out_ready = 1'b1;
    while (!u_if.out_valid && n < 100) begin
      step();
      n++;
    end
    check({name, "_valid"}, u_if.out_valid, 1);
    check({name, "_data"}, u_if.out_data, eq);
    check({name, "_rem"}, u_if.out_rem, er);
    check({name, "_tag"}, u_if.out_tag, et);
    step();
  endtask

  task automatic aux_xact(input string name, input logic [31:0] d,
                          input logic [31:0] q1, input logic [31:0] r1,
                          input logic [31:0] q3, input logic [31:0] r3);
    int n = 0;
    check({name, "_ready"}, u_if1.in_ready & u_if3.in_ready, 1);
    u_if1.in_valid = 1'b1; u_if1.in_data = d; u_if1.in_tag = 8'h3C;
    u_if3.in_valid = 1'b1; u_if3.in_data = d; u_if3.in_tag = 8'h3C;
    step();
    u_if1.in_valid = 1'b0;
    u_if3.in_valid = 1'b0;
    while (!u_if1.out_valid && n < 60) begin
      step();
      n++;
    end
    check({name, "_d1_valid"}, u_if1.out_valid, 1);
    check({name, "_d1_data"}, u_if1.out_data, q1);
    check({name, "_d1_rem"}, u_if1.out_rem, r1);
    check({name, "_d3_valid"}, u_if3.out_valid, 1);
    check({name, "_d3_data"}, u_if3.out_data, q3);
    check({name, "_d3_rem"}, u_if3.out_rem, r3);
    check({name, "_d3_tag"}, u_if3.out_tag, 8'h3C);
    step();
  endtask

  // stream vectors with hand-computed quotient/remainder for DIVISOR=256
  logic [31:0] sv_data[8] = '{32'd123456, 32'hFFFE1DC0, 32'h7FFFFFFF, 32'h80000000,
                              32'd255, 32'hFFFFFF00, 32'd0, 32'hFFFFFFFF};
  logic [31:0] sv_quo[8]  = '{32'd482, 32'hFFFFFE1E, 32'd8388607, 32'hFF800000,
                              32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [31:0] sv_rem[8]  = '{32'd64, 32'hFFFFFFC0, 32'd255, 32'd0,
                              32'd255, 32'd0, 32'd0, 32'hFFFFFFFF};

  initial begin
    #500000;
    $display("FAIL watchdog timeout n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_base;
    int got;
    int cyc;
    logic rdy;
    logic [71:0] e;

    rst = 1'b1;
    u_if.in_valid = 1'b0;  u_if.in_data = '0;  u_if.in_tag = '0;  u_if.out_ready = 1'b0;
    u_if1.in_valid = 1'b0; u_if1.in_data = '0; u_if1.in_tag = '0; u_if1.out_ready = 1'b1;
    u_if3.in_valid = 1'b0; u_if3.in_data = '0; u_if3.in_tag = '0; u_if3.out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    check("rst_in_ready", u_if.in_ready, 1);
    check("rst_out_valid", u_if.out_valid, 0);
    check("rst_out_data", u_if.out_data, 0);
    check("rst_out_rem", u_if.out_rem, 0);
    check("rst_out_tag", u_if.out_tag, 0);

    // exact latency: valid rises after the 32nd edge following accept
    send(32'd1000, 8'h05);
    repeat (31) step();
    check("lat_not_early", u_if.out_valid, 0);
    step();
    check("lat_exact", u_if.out_valid, 1);
    check("p1000_data", u_if.out_data, 32'd3);
    check("p1000_rem", u_if.out_rem, 32'd232);
    check("p1000_tag", u_if.out_tag, 8'h05);
    check("done_in_ready", u_if.in_ready, 0);
    u_if.out_ready = 1'b1;
    step();
    check("post_hs_in_ready", u_if.in_ready, 1);
    check("post_hs_out_valid", u_if.out_valid, 0);

    send(32'hFFFFFC18, 8'h06);
    recv("n1000", 32'hFFFFFFFD, 32'hFFFFFF18, 8'h06);
    send(32'hFFFFFF01, 8'h07);
    recv("n255", 32'd0, 32'hFFFFFF01, 8'h07);

    aux_xact("aux7", 32'd7, 32'd7, 32'd0, 32'd2, 32'd1);
    aux_xact("auxmin", 32'h80000000, 32'h80000000, 32'd0, 32'hD5555556, 32'hFFFFFFFE);

    // backpressure: output held, second request refused until handshake
    u_if.out_ready = 1'b0;
    send(32'd300, 8'h11);
    cyc = 0;
    while (!u_if.out_valid && cyc < 60) begin
      step();
      cyc++;
    end
    check("bp_valid", u_if.out_valid, 1);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 32'd42;
    u_if.in_tag   = 8'h22;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", u_if.out_valid, 1);
      check("bp_hold_data", u_if.out_data, 32'd1);
      check("bp_hold_rem", u_if.out_rem, 32'd44);
      check("bp_hold_tag", u_if.out_tag, 8'h11);
      check("bp_in_ready", u_if.in_ready, 0);
    end
    hs_base = hs_cnt;
    u_if.out_ready = 1'b1;
    step();
    check("bp_one_hs", hs_cnt, hs_base + 1);
    check("bp_valid_drop", u_if.out_valid, 0);
    check("bp_ready_back", u_if.in_ready, 1);
    step();
    u_if.in_valid = 1'b0;
    check("bp_42_accepted", u_if.in_ready, 0);
    check("bp_still_one_hs", hs_cnt, hs_base + 1);
    recv("bp42", 32'd0, 32'd42, 8'h22);

    // reset in the middle of a divide
    send(32'd5000, 8'h33);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", u_if.in_ready, 1);
    check("mid_rst_out_valid", u_if.out_valid, 0);
    check("mid_rst_out_data", u_if.out_data, 0);
    hs_base = hs_cnt;
    u_if.out_ready = 1'b1;
    repeat (40) step();
    check("no_stale_hs", hs_cnt, hs_base);
    check("no_stale_valid", u_if.out_valid, 0);
    send(32'd512, 8'h44);
    recv("p512", 32'd2, 32'd0, 8'h44);

    // stream with random downstream stalls, scoreboard in order
    got = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back({8'(8'h10 + i), sv_quo[i], sv_rem[i]});
          send(sv_data[i], 8'(8'h10 + i));
        end
      end
      begin
        cyc = 0;
        while (got < 8 && cyc < 4000) begin
          rdy = 1'($urandom_range(0, 1));
          u_if.out_ready = rdy;
          if (u_if.out_valid && rdy) begin
            check("stream_q_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("stream_data", u_if.out_data, e[63:32]);
            check("stream_rem", u_if.out_rem, e[31:0]);
            check("stream_tag", u_if.out_tag, e[71:64]);
            got++;
          end
          step();
          cyc++;
        end
      end
    join
    check("stream_count", got, 8);
    check("stream_q_empty", exp_q.size(), 0);
    repeat (40) step();
    check("stream_no_extra", u_if.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
